systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Skewed operand feeder that drives the left and top edges of the N×N systolic multiplier built from accumulator_cells PEs. It buffers two N×N operand matrices A and B through a word-write port and, on start, streams row i of A into PE row i and column j of B into PE column j, with the diagonal skew the array requires. It then holds the edges at zero until the last PE has captured its final product, and signals completion. It is the transmit end of the PE a/b/valid_i interface.

## Interface
- WIDTH, 16, operand width; equal to the PE WIDTH
- N, 4, array dimension (N ≥ 2)
- clock  in  1  rising-edge clock
- nreset  in  1  reset, asynchronous, active-low
- wr_en  in  1  buffer write strobe
- wr_sel  in  1  0 = matrix A, 1 = matrix B
- wr_row  in  $clog2(N)  element row index
- wr_col  in  $clog2(N)  element column index
- wr_data  in  WIDTH  element value
- start  in  1  begin streaming; single-cycle request
- busy  out  1  stream/flush in progress
- done  out  1  one-cycle completion pulse
- a_o  out  N*WIDTH  slice i ([i*WIDTH +: WIDTH]) drives the `a` input of PE(i,0)
- b_o  out  N*WIDTH  slice j drives the `b` input of PE(0,j)
- valid_row_o  out  N  bit i drives `valid_i` of PE row i
- valid_col_o  out  N  bit j drives `valid_i` of PE column j

## Operation
- Buffers:
  - Two N×N WIDTH-bit register arrays, A and B.
  - A write updates A[wr_row][wr_col] or B[wr_row][wr_col] on the clock edge when wr_en=1 and state ∈ {IDLE}.
  - Writes in any other state are dropped.
  - A write in the same cycle as an accepted start is committed before the first read.
- FSM states: IDLE, STREAM, FLUSH, DONE.
  - IDLE: start=1 → STREAM, t=0. Otherwise stay in IDLE.
  - STREAM: t increments each cycle. At t=2N-2 → FLUSH.
  - FLUSH: N cycles with all edges at zero → DONE.
  - DONE: one cycle → IDLE.
  - start outside IDLE is ignored (not queued).
- Skew, per STREAM cycle t:
  - a_o slice i = A[i][t-i] when 0 ≤ t-i ≤ N-1, else 0.
  - b_o slice j = B[t-j][j] when 0 ≤ t-j ≤ N-1, else 0.
  - valid_row_o[i] = 1 exactly when slice i carries a buffer element; same rule for valid_col_o[j].
- FLUSH, DONE, IDLE: a_o, b_o, valid_row_o, valid_col_o all 0.
- Arithmetic: none. Values are passed through unmodified at WIDTH bits. The t counter is $clog2(2N) bits wide and never wraps inside STREAM.
- Buffers retain their contents across runs; re-starting reuses the same operands.
- Clearing PE accumulators between runs is not this block's job.
- Reset mid-operation: all state returns to IDLE immediately and asynchronously; buffers clear to 0 and all outputs go to 0.

## Timing
- Reset values:
  - busy=0, done=0
  - a_o=0, b_o=0
  - valid_row_o=0, valid_col_o=0
  - state=IDLE, t=0, all buffer words 0
- All outputs are registered.
- Start sampled at edge E0 → cycle after E0 is STREAM t=0. a_o/b_o carry the t=0 values in that cycle.
- busy is high for all STREAM and FLUSH cycles: 3N-1 cycles (11 for N=4). busy is low in DONE.
- done is high only in the DONE cycle, i.e. 3N cycles after the start edge.
- A start in the cycle after DONE is accepted.
- Latency rationale:
  - PE(i,j) receives A[i][k] and B[k][j] at t=i+j+k.
  - The last pair arrives at t=3N-3 (PE(N-1,N-1)).
  - Its accumulator is updated at the following edge, which falls inside FLUSH.
  - Therefore every PE z is final when done=1.

## Test plan
- Reset state:
  - Stimulus: nreset low mid-STREAM (N=4, t=3).
  - Required: all outputs 0 and busy=0 immediately; a subsequent start streams zeros (buffers cleared).
- Skew pattern:
  - Stimulus: N=4, A[i][k]=16i+k+1, B[k][j]=16k+j+0x80, then start.
  - Required at t=0: a_o = {0,0,0,1}, valid_row_o=0001.
  - Required at t=3: row 3 slice = 0x31, row 0 slice = 0x04.
  - Required at t=6: only slice 3 is nonzero (0x34 on a_o, 0xB3 on b_o).
- Handshake timing:
  - Stimulus: start at cycle 0.
  - Required: busy high cycles 1–11, done high exactly at cycle 12, returning to IDLE at cycle 13.
- Ignored requests:
  - Stimulus: start and wr_en (A[0][0]=0xFFFF) asserted during STREAM.
  - Required: no restart; A[0][0] unchanged on the next run.
- End-to-end with a 4×4 PE array:
  - Stimulus: A = identity, B[k][j]=k*4+j.
  - Required: at done, PE(i,j).z = i*4+j.
  - Stimulus: A = B = all 2s.
  - Required: every z = 16.
- Back-to-back runs:
  - Stimulus: start in the cycle immediately after done.
  - Required: accepted, identical stream reproduced.

Source files
------------

// File: rtl/systolic_feeder_if.sv
// Operand-load / start port and skewed edge outputs of the systolic feeder.
// master drives buffer writes and start; slave is the feeder itself.
interface systolic_feeder_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 4
);
    localparam int unsigned IW = $clog2(N);

    logic                 wr_en;
    logic                 wr_sel;
    logic [IW-1:0]        wr_row;
    logic [IW-1:0]        wr_col;
    logic [WIDTH-1:0]     wr_data;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [N*WIDTH-1:0]   a_o;
    logic [N*WIDTH-1:0]   b_o;
    logic [N-1:0]         valid_row_o;
    logic [N-1:0]         valid_col_o;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  busy, done, a_o, b_o, valid_row_o, valid_col_o
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output busy, done, a_o, b_o, valid_row_o, valid_col_o
    );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers two NxN operand matrices and streams them, diagonally skewed, into the
// left (A rows) and top (B columns) edges of an NxN systolic multiplier array.
module systolic_feeder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 4
) (
    input  logic             clock,
    input  logic             nreset,
    systolic_feeder_if.slave bus
);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned TW = $clog2(2 * N);
    localparam logic [TW-1:0] StreamLast = TW'(2 * N - 2);
    localparam logic [TW-1:0] FlushLast  = TW'(N - 1);

    typedef enum logic [1:0] {StIdle, StStream, StFlush, StDone} state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [TW-1:0]      r_t;
    logic [TW-1:0]      w_t_nxt;
    logic [WIDTH-1:0]   r_a [N][N];
    logic [WIDTH-1:0]   r_b [N][N];
    logic [N*WIDTH-1:0] r_a_o;
    logic [N*WIDTH-1:0] r_b_o;
    logic [N-1:0]       r_valid_row;
    logic [N-1:0]       r_valid_col;
    logic               r_busy;
    logic               r_done;

    logic               w_wr_ok;
    logic [N*WIDTH-1:0] w_a_nxt;
    logic [N*WIDTH-1:0] w_b_nxt;
    logic [N-1:0]       w_vr_nxt;
    logic [N-1:0]       w_vc_nxt;

    assign w_wr_ok = bus.wr_en && (r_state == StIdle);

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_nxt = StStream;
                    w_t_nxt     = '0;
                end
            end
            StStream: begin
                if (r_t == StreamLast) begin
                    w_state_nxt = StFlush;
                    w_t_nxt     = '0;
                end else begin
                    w_t_nxt = r_t + 1'b1;
                end
            end
            StFlush: begin
                if (r_t == FlushLast) begin
                    w_state_nxt = StDone;
                    w_t_nxt     = '0;
                end else begin
                    w_t_nxt = r_t + 1'b1;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
                w_t_nxt     = '0;
            end
            default: begin
                w_state_nxt = StIdle;
                w_t_nxt     = '0;
            end
        endcase
    end

    // Element (x,y) meets the edge when t == x+y: A[x][y] on row x, B[x][y] on column y.
    // A write landing with start is forwarded so the first beat sees it.
    always_comb begin
        w_a_nxt  = '0;
        w_b_nxt  = '0;
        w_vr_nxt = '0;
        w_vc_nxt = '0;
        if (w_state_nxt == StStream) begin
            for (int unsigned x = 0; x < N; x++) begin
                for (int unsigned y = 0; y < N; y++) begin
                    if (w_t_nxt == TW'(x + y)) begin
                        w_a_nxt[x*WIDTH +: WIDTH] =
                            (w_wr_ok && !bus.wr_sel && bus.wr_row == IW'(x) &&
                             bus.wr_col == IW'(y)) ? bus.wr_data : r_a[x][y];
                        w_b_nxt[y*WIDTH +: WIDTH] =
                            (w_wr_ok && bus.wr_sel && bus.wr_row == IW'(x) &&
                             bus.wr_col == IW'(y)) ? bus.wr_data : r_b[x][y];
                        w_vr_nxt[x] = 1'b1;
                        w_vc_nxt[y] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state     <= StIdle;
            r_t         <= '0;
            r_a_o       <= '0;
            r_b_o       <= '0;
            r_valid_row <= '0;
            r_valid_col <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int unsigned x = 0; x < N; x++) begin
                for (int unsigned y = 0; y < N; y++) begin
                    r_a[x][y] <= '0;
                    r_b[x][y] <= '0;
                end
            end
        end else begin
            r_state     <= w_state_nxt;
            r_t         <= w_t_nxt;
            r_a_o       <= w_a_nxt;
            r_b_o       <= w_b_nxt;
            r_valid_row <= w_vr_nxt;
            r_valid_col <= w_vc_nxt;
            r_busy      <= (w_state_nxt == StStream) || (w_state_nxt == StFlush);
            r_done      <= (w_state_nxt == StDone);
            if (w_wr_ok) begin
                if (bus.wr_sel) begin
                    r_b[bus.wr_row][bus.wr_col] <= bus.wr_data;
                end else begin
                    r_a[bus.wr_row][bus.wr_col] <= bus.wr_data;
                end
            end
        end
    end

    assign bus.a_o         = r_a_o;
    assign bus.b_o         = r_b_o;
    assign bus.valid_row_o = r_valid_row;
    assign bus.valid_col_o = r_valid_col;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder with a behavioural NxN multiply-accumulate array
// attached to its edges; expected streams and products come from plain matrix arithmetic.
module tb_systolic_feeder;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned N     = 4;
    localparam int unsigned IW    = $clog2(N);
    localparam int unsigned CW    = N * WIDTH;
    typedef logic [CW-1:0] cw_t;

    typedef struct {
        cw_t          a;
        cw_t          b;
        logic [N-1:0] vr;
        logic [N-1:0] vc;
        logic         busy;
        logic         done;
    } exp_t;

    logic clock;
    logic nreset;

    systolic_feeder_if #(.WIDTH(WIDTH), .N(N)) bus ();

    systolic_feeder #(.WIDTH(WIDTH), .N(N)) u_dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] ma [N][N];
    logic [WIDTH-1:0] mb [N][N];
    logic [31:0]      exp_z [N][N];
    exp_t             q [$];

    task automatic check(input string name, input cw_t act, input cw_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: element A[i][k] sits on row i when t == i+k; B[k][j] on column j when t == k+j.
    task automatic push_run();
        exp_t e;
        for (int t = 0; t <= 2 * N - 2; t++) begin
            e.a = '0; e.b = '0; e.vr = '0; e.vc = '0; e.busy = 1'b1; e.done = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (t - i >= 0 && t - i <= N - 1) begin
                    e.a[i*WIDTH +: WIDTH] = ma[i][t-i];
                    e.vr[i] = 1'b1;
                    e.b[i*WIDTH +: WIDTH] = mb[t-i][i];
                    e.vc[i] = 1'b1;
                end
            end
            q.push_back(e);
        end
        e.a = '0; e.b = '0; e.vr = '0; e.vc = '0;
        for (int f = 0; f < N; f++) q.push_back(e);
        e.busy = 1'b0; e.done = 1'b1;
        q.push_back(e);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                exp_z[i][j] = 0;
                for (int k = 0; k < N; k++) exp_z[i][j] += 32'(ma[i][k]) * 32'(mb[k][j]);
            end
        end
    endtask

    // Behavioural PE array: operands ripple right/down one PE per cycle.
    logic [WIDTH-1:0] pa [N][N];
    logic [WIDTH-1:0] pb [N][N];
    logic             pva [N][N];
    logic             pvb [N][N];
    logic [WIDTH-1:0] ain [N][N];
    logic [WIDTH-1:0] bin [N][N];
    logic             vain [N][N];
    logic             vbin [N][N];
    logic [31:0]      pz [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) begin
                    ain[i][j]  = bus.a_o[i*WIDTH +: WIDTH];
                    vain[i][j] = bus.valid_row_o[i];
                end else begin
                    ain[i][j]  = pa[i][j-1];
                    vain[i][j] = pva[i][j-1];
                end
                if (i == 0) begin
                    bin[i][j]  = bus.b_o[j*WIDTH +: WIDTH];
                    vbin[i][j] = bus.valid_col_o[j];
                end else begin
                    bin[i][j]  = pb[i-1][j];
                    vbin[i][j] = pvb[i-1][j];
                end
            end
        end
    end

    always @(posedge clock or negedge nreset) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!nreset) begin
                    pa[i][j] <= '0; pb[i][j] <= '0; pva[i][j] <= 1'b0; pvb[i][j] <= 1'b0;
                    pz[i][j] <= '0;
                end else begin
                    pa[i][j]  <= ain[i][j];
                    pb[i][j]  <= bin[i][j];
                    pva[i][j] <= vain[i][j];
                    pvb[i][j] <= vbin[i][j];
                    if (bus.start && !bus.busy && !bus.done) pz[i][j] <= '0;
                    else if (vain[i][j] && vbin[i][j])
                        pz[i][j] <= pz[i][j] + 32'(ain[i][j]) * 32'(bin[i][j]);
                end
            end
        end
    end

    // Monitor: every active DUT cycle consumes one expected beat.
    always @(negedge clock) begin
        if (nreset) begin
            if (bus.busy || bus.done) begin
                if (q.size() == 0) begin
                    check("unexpected_activity", cw_t'({bus.busy, bus.done}), '0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("a_o", bus.a_o, e.a);
                    check("b_o", bus.b_o, e.b);
                    check("valid_row_o", cw_t'(bus.valid_row_o), cw_t'(e.vr));
                    check("valid_col_o", cw_t'(bus.valid_col_o), cw_t'(e.vc));
                    check("busy", cw_t'(bus.busy), cw_t'(e.busy));
                    check("done", cw_t'(bus.done), cw_t'(e.done));
                    if (bus.done) begin
                        for (int i = 0; i < N; i++)
                            for (int j = 0; j < N; j++)
                                check($sformatf("pe_z[%0d][%0d]", i, j),
                                      cw_t'(pz[i][j]), cw_t'(exp_z[i][j]));
                    end
                end
            end else begin
                check("idle_edges", bus.a_o | bus.b_o |
                      cw_t'(bus.valid_row_o) | cw_t'(bus.valid_col_o), '0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_elem(input bit sel, input int r, input int c, input logic [WIDTH-1:0] d);
        bus.wr_en = 1'b1; bus.wr_sel = sel;
        bus.wr_row = IW'(r); bus.wr_col = IW'(c); bus.wr_data = d;
        if (sel) mb[r][c] = d; else ma[r][c] = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    // Issue start (optionally with a same-cycle write), wait for done, check latency.
    task automatic run(input bit with_wr, input bit sel, input int r, input int c,
                       input logic [WIDTH-1:0] d);
        int cyc;
        bus.start = 1'b1;
        if (with_wr) begin
            bus.wr_en = 1'b1; bus.wr_sel = sel;
            bus.wr_row = IW'(r); bus.wr_col = IW'(c); bus.wr_data = d;
            if (sel) mb[r][c] = d; else ma[r][c] = d;
        end
        push_run();
        tick();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 64) begin
            tick();
            cyc++;
        end
        check("done_latency", cw_t'(cyc), cw_t'(3 * N));
        tick();
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
        bus.wr_data = '0; bus.start = 1'b0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            ma[i][j] = '0; mb[i][j] = '0;
        end
        nreset = 1'b0;
        #1;
        check("reset_busy", cw_t'(bus.busy), '0);
        check("reset_done", cw_t'(bus.done), '0);
        check("reset_a_o", bus.a_o, '0);
        repeat (2) tick();
        nreset = 1'b1;
        repeat (2) tick();

        // Skew pattern
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            write_elem(1'b0, i, j, WIDTH'(16 * i + j + 1));
            write_elem(1'b1, i, j, WIDTH'(16 * i + j + 'h80));
        end
        run(1'b0, 1'b0, 0, 0, '0);

        // Ignored start and write during STREAM; rerun must reproduce the same stream
        bus.start = 1'b1;
        push_run();
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_sel = 1'b0;
        bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = 16'hFFFF;
        tick();
        bus.start = 1'b0; bus.wr_en = 1'b0;
        for (int n = 0; n < 64 && !bus.done; n++) tick();
        tick();
        run(1'b0, 1'b0, 0, 0, '0);

        // Identity times ramp, then all-twos
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            write_elem(1'b0, i, j, (i == j) ? WIDTH'(1) : WIDTH'(0));
            write_elem(1'b1, i, j, WIDTH'(i * 4 + j));
        end
        run(1'b0, 1'b0, 0, 0, '0);
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            write_elem(1'b0, i, j, WIDTH'(2));
            write_elem(1'b1, i, j, WIDTH'(2));
        end
        run(1'b0, 1'b0, 0, 0, '0);
        run(1'b0, 1'b0, 0, 0, '0);

        // Random operands, write coincident with start, back-to-back runs
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
                write_elem(1'b0, i, j, WIDTH'($urandom));
                write_elem(1'b1, i, j, WIDTH'($urandom));
            end
            run(1'b1, 1'($urandom), int'($urandom_range(N - 1)), int'($urandom_range(N - 1)),
                WIDTH'($urandom));
            run(1'b0, 1'b0, 0, 0, '0);
        end

        // Reset mid-STREAM at t=3 clears everything
        bus.start = 1'b1;
        push_run();
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        nreset = 1'b0;
        #1;
        check("midreset_busy", cw_t'(bus.busy), '0);
        check("midreset_a_o", bus.a_o, '0);
        check("midreset_b_o", bus.b_o, '0);
        check("midreset_valid", cw_t'({bus.valid_row_o, bus.valid_col_o}), '0);
        q.delete();
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            ma[i][j] = '0; mb[i][j] = '0;
        end
        tick();
        nreset = 1'b1;
        tick();
        run(1'b0, 1'b0, 0, 0, '0);

        repeat (3) tick();
        check("queue_drained", cw_t'(q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
